sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per frame, legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on posedge clk.
REQ-004 d_in  input  1  serial bit stream, one bit per clk; idle level 0.
REQ-005 data_out  output  WIDTH  last accepted frame; bit 0 is the first data bit received.
REQ-006 valid  output  1  data_out holds an unconsumed frame.
REQ-007 ready  input  1  consumer accepts data_out on any posedge where valid && ready.
REQ-008 busy  output  1  high while a frame is being received (state != IDLE).
REQ-009 overrun  output  1  sticky flag: a completed frame was dropped because the holding register was full.
REQ-010 parity_err  output  1  one-cycle pulse: a completed frame failed its parity check.

Function
REQ-011 Frame format SHALL be: start bit (d_in=1 sampled in IDLE), then WIDTH data bits, LSB first, one per clk, then one parity bit when PARITY_EN is defined.
REQ-012 The FSM SHALL have states IDLE, DATA and PARITY; PARITY exists only when PARITY_EN is defined.
REQ-013 IDLE->DATA on a posedge with d_in=1; otherwise remain in IDLE.
REQ-014 In DATA, a bit counter SHALL count 0..WIDTH-1; the shift register captures d_in at each edge.
REQ-015 On the WIDTH-th data edge, the FSM SHALL go to PARITY if PARITY_EN is defined, else to IDLE with the frame completed.
REQ-016 PARITY->IDLE unconditionally after one edge; the frame is complete only if the XOR of the data bits and the parity bit is 0 (even parity).
REQ-017 Latency: with start bit sampled at edge N, valid SHALL be high after edge N+WIDTH (N+WIDTH+1 with PARITY_EN).
REQ-018 A completed frame SHALL load data_out and set valid when valid=0, or when valid && ready on that same edge.
REQ-019 If valid && !ready at completion, the new frame SHALL be dropped, data_out kept unchanged, and overrun set.
REQ-020 valid SHALL clear on an edge with valid && ready and no simultaneous completion.
REQ-021 data_out SHALL change only on a load; it is stable while valid=1.
REQ-022 A parity failure SHALL drop the frame, leave valid and data_out unchanged, and pulse parity_err for exactly one cycle.
REQ-023 Back-to-back frames SHALL be supported: a start bit sampled on the first edge after a frame returns to IDLE is accepted.
REQ-024 d_in values during DATA/PARITY SHALL never be interpreted as a start bit.
REQ-025 busy SHALL be 1 in DATA and PARITY, and 0 in IDLE.

Reset
REQ-026 With rst=1 at a posedge: state=IDLE, counter=0, shift register=0, data_out=0, valid=0, overrun=0, parity_err=0, busy=0.
REQ-027 rst SHALL take priority over all other events, including mid-frame and on a completing edge; a partial frame is discarded.
REQ-028 overrun SHALL clear only via rst.

Configuration
REQ-029 Macro SIPO_DESER_PARITY_EN: when defined, the PARITY state and check are built in and the frame is WIDTH+2 bits long.
REQ-030 When SIPO_DESER_PARITY_EN is undefined, there is no PARITY state, parity_err is tied to 0, and the frame is WIDTH+1 bits long.

Verification
REQ-031 Reset: rst=1 for 2 cycles with d_in=1 -> all outputs 0, busy=0.
REQ-032 Single frame: WIDTH=8, no parity, bits 1,0,1,0,0,1,0,1,1 (start first), ready=1 -> data_out=8'hD2, valid high for exactly 1 cycle at edge N+8.
REQ-033 Back-pressure/overrun: ready=0, send 8'hA5 then 8'h3C back-to-back -> data_out stays 8'hA5, valid=1, overrun=1.
REQ-034 Simultaneous consume and complete: valid=1 (8'h11), ready=1 on the completion edge of 8'h22 -> data_out=8'h22, valid stays 1, overrun=0.
REQ-035 Parity (macro defined): 8'h01 with parity bit 0 -> parity_err pulses 1 cycle, valid stays 0; same data with parity bit 1 -> data_out=8'h01.
REQ-036 Reset mid-frame: rst=1 after 4 data bits, then a full frame of 8'hFF -> data_out=8'hFF, with no residue from the aborted frame.

Source files
------------

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with a one-word holding register.
// Latency: start bit at edge N -> valid after edge N+WIDTH (N+WIDTH+1 with SIPO_DESER_PARITY_EN).
// Backpressure: a frame completing while valid && !ready is dropped and overrun is set (sticky).
// Build option: define SIPO_DESER_PARITY_EN to add an even-parity bit after the data bits.
module sipo_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] frame;
    logic             done;
    logic             perr;

    // Bits arrive LSB first, so shifting right leaves the first bit in bit 0.
    assign shift_nxt = {d_in, shreg[WIDTH-1:1]};
    assign busy      = (state != IDLE);

    // Decide whether this edge completes a good frame (or fails the parity check).
    always_comb begin
        done  = 1'b0;
        perr  = 1'b0;
        frame = shift_nxt;
`ifdef SIPO_DESER_PARITY_EN
        frame = shreg;
        if (state == PARITY) begin
            done = ~(^{shreg, d_in});
            perr = ^{shreg, d_in};
        end
`else
        perr = 1'b0;
        done = (state == DATA) && (cnt == LAST);
`endif
    end

`ifndef SIPO_DESER_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Receive FSM plus holding-register handshake; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (d_in) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    shreg <= shift_nxt;
                    if (cnt == LAST) begin
                        cnt <= '0;
`ifdef SIPO_DESER_PARITY_EN
                        state <= PARITY;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SIPO_DESER_PARITY_EN
                PARITY: begin
                    state <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef SIPO_DESER_PARITY_EN
            parity_err <= perr;
`endif

            // A consume on the completion edge frees the register for the new frame.
            if (done) begin
                if (!valid || ready) begin
                    data_out <= frame;
                    valid    <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: scoreboard bench for sipo_deser (WIDTH=8).
// Latency: frames checked at completion edge and on consumption.
// Backpressure: ready driven by the stimulus; consumption compared against the queue.
module tb_sipo_deser;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             d_in;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    sipo_deser #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .ready      (ready),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends start + data (+ parity). Returns #1 after the completing edge.
    // flip inverts the even-parity bit; rdy_end raises ready for the final edge only.
    task automatic send_frame(input logic [WIDTH-1:0] data, input logic flip, input logic rdy_end);
        logic par;
        par  = (^data) ^ flip;
        d_in = 1'b1;
        tick();
        check("busy_start", busy, 1);
        for (int i = 0; i < WIDTH; i++) begin
            d_in = data[i];
`ifndef SIPO_DESER_PARITY_EN
            if (i == WIDTH - 1 && rdy_end) ready = 1'b1;
`endif
            tick();
        end
`ifdef SIPO_DESER_PARITY_EN
        d_in = par;
        if (rdy_end) ready = 1'b1;
        tick();
`else
        if (par && flip) d_in = 1'b0;
`endif
        d_in = 1'b0;
    endtask

    // Scoreboard: a consumption happens on the next edge whenever valid && ready here.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", exp_q.size(), 1);
            end else begin
                check("sb_data", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] r;
        rst   = 1'b1;
        d_in  = 1'b1;
        ready = 1'b0;
        tick();
        tick();
        check("rst_data", data_out, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_perr", parity_err, 0);
        check("rst_busy", busy, 0);
        rst  = 1'b0;
        d_in = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Single frame D2 with ready high: valid for exactly one cycle.
        ready = 1'b1;
        exp_q.push_back(8'hD2);
        send_frame(8'hD2, 1'b0, 1'b0);
        check("d2_valid", valid, 1);
        check("d2_busy", busy, 0);
        check("d2_data", data_out, 8'hD2);
        tick();
        check("d2_valid_drop", valid, 0);

        // Back-pressure: second frame is dropped, overrun is sticky.
        ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        check("ovr_data", data_out, 8'hA5);
        check("ovr_valid", valid, 1);
        check("ovr_flag", overrun, 1);
        ready = 1'b1;
        tick();
        check("ovr_consumed", valid, 0);
        check("ovr_sticky", overrun, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovr_cleared", overrun, 0);

        // Consume and complete on the same edge.
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0);
        check("sim_first", data_out, 8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b0, 1'b1);
        check("sim_data", data_out, 8'h22);
        check("sim_valid", valid, 1);
        check("sim_overrun", overrun, 0);
        tick();

`ifdef SIPO_DESER_PARITY_EN
        // Bad parity drops the frame and pulses parity_err once.
        ready = 1'b1;
        send_frame(8'h01, 1'b1, 1'b0);
        check("par_err_pulse", parity_err, 1);
        check("par_valid", valid, 0);
        tick();
        check("par_err_clear", parity_err, 0);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b0, 1'b0);
        check("par_good", data_out, 8'h01);
        check("par_good_err", parity_err, 0);
        tick();
`endif

        // Reset in the middle of a frame, then a clean FF frame.
        ready = 1'b1;
        d_in  = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            d_in = i[0];
            tick();
        end
        rst  = 1'b1;
        d_in = 1'b1;
        tick();
        rst  = 1'b0;
        d_in = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", valid, 0);
        tick();
        check("mid_rst_idle", busy, 0);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b0, 1'b0);
        check("mid_rst_data", data_out, 8'hFF);
        tick();

        // Random back-to-back frames with ready high.
        for (int k = 0; k < 6; k++) begin
            r = WIDTH'($urandom_range(0, 255));
            exp_q.push_back(r);
            send_frame(r, 1'b0, 1'b0);
            check("rand_valid", valid, 1);
        end
        tick();
        tick();
        check("sb_drain", exp_q.size(), 0);
        check("end_overrun", overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
